// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the RISC-V control path: FSM states, opcodes,
// datapath select codes and ALU control codes.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    ILLEGAL  = 4'd11
  } stateT;

  // High-level ALU request from the FSM; the decoder refines FUNCT.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluOpT;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format depends only on the opcode, so it is valid in every state.
  function automatic logic [1:0] immSrcFor(input logic [6:0] op);
    case (op)
      OP_STORE:  immSrcFor = IMM_S;
      OP_BRANCH: immSrcFor = IMM_B;
      OP_JAL:    immSrcFor = IMM_J;
      default:   immSrcFor = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU control decode shared by the multicycle and single-cycle cores.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  aluOpT      aluOp,
  input  logic [2:0] funct3,
  input  logic       opb5,
  input  logic       funct7b5,
  output logic [2:0] aluControl
);

  // Map the FSM request plus funct fields onto an ALU operation.
  always_comb begin
    aluControl = ALU_ADD;
    case (aluOp)
      ALUOP_SUB: aluControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type (op[5]=1) can subtract; addi ignores bit 30.
          3'b000:  aluControl = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  aluControl = ALU_SLT;
          3'b110:  aluControl = ALU_OR;
          3'b111:  aluControl = ALU_AND;
          default: aluControl = ALU_ADD;
        endcase
      end
      default: aluControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: sequences fetch, decode, memory, ALU,
// jump and branch steps and produces all datapath enables and selects.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal,
  output logic       retire
);

  stateT stateReg;
  stateT stateNext;
  aluOpT aluOp;

  alu_decoder aluDec (
    .aluOp     (aluOp),
    .funct3    (funct3),
    .opb5      (op[5]),
    .funct7b5  (funct7b5),
    .aluControl(alu_control)
  );

  assign imm_src = immSrcFor(op);

  // State register; reset lands in FETCH from anywhere, including mid-access.
  always_ff @(posedge clk) begin
    if (rst) stateReg <= FETCH;
    else     stateReg <= stateNext;
  end

  // Next-state and Moore/Mealy outputs; everything defaults to 0 / select 00.
  always_comb begin
    stateNext  = stateReg;
    aluOp      = ALUOP_ADD;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_REGB;
    illegal    = 1'b0;
    retire     = 1'b0;
    case (stateReg)
      FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          // Latch the instruction and advance PC by 4 in the same cycle.
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALU;
          stateNext  = DECODE;
        end
      end
      DECODE: begin
        // Precompute the branch/jump target while decoding.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: stateNext = MEMADR;
          OP_RTYPE:          stateNext = EXECR;
          OP_ITYPE:          stateNext = EXECI;
          OP_JAL:            stateNext = JAL;
          OP_BRANCH:         stateNext = BEQ;
          default:           stateNext = ILLEGAL;
        endcase
      end
      MEMADR: begin
        alu_src_a = SRCA_REGA;
        alu_src_b = SRCB_IMM;
        stateNext = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        mem_read = 1'b1;
        adr_src  = 1'b1;
        if (mem_ready) stateNext = MEMWB;
      end
      MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        retire     = 1'b1;
        stateNext  = FETCH;
      end
      MEMWRITE: begin
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) begin
          retire    = 1'b1;
          stateNext = FETCH;
        end
      end
      EXECR: begin
        alu_src_a = SRCA_REGA;
        alu_src_b = SRCB_REGB;
        aluOp     = ALUOP_FUNCT;
        stateNext = ALUWB;
      end
      EXECI: begin
        alu_src_a = SRCA_REGA;
        alu_src_b = SRCB_IMM;
        aluOp     = ALUOP_FUNCT;
        stateNext = ALUWB;
      end
      ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        retire     = 1'b1;
        stateNext  = FETCH;
      end
      JAL: begin
        // PC takes the target from ALUOut; ALU forms the link address OldPC+4.
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        stateNext  = ALUWB;
      end
      BEQ: begin
        alu_src_a  = SRCA_REGA;
        alu_src_b  = SRCB_REGB;
        aluOp      = ALUOP_SUB;
        result_src = RES_ALUOUT;
        pc_write   = zero;
        retire     = 1'b1;
        stateNext  = FETCH;
      end
      ILLEGAL: begin
        // Trap state: only reset leaves it, so the flag is sticky.
        illegal   = 1'b1;
        stateNext = ILLEGAL;
      end
      default: stateNext = FETCH;
    endcase
    // No side effects or memory requests may escape while reset is held.
    if (rst) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      retire    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus
// randomized instruction streams against a per-instruction behavioural model.
module tb_multicycle_controller;

  localparam logic [6:0] T_LW  = 7'b0000011;
  localparam logic [6:0] T_SW  = 7'b0100011;
  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_JAL = 7'b1101111;
  localparam logic [6:0] T_BEQ = 7'b1100011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_read, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic       illegal, retire;

  int errors = 0;
  int checks = 0;

  // Observations gathered by runInstr for the calling test to judge.
  int         oCycles, oRegWr, oRegWrCycle, oRes01, oPcWr, oIrWr;
  int         oMemWr, oMemWrAdr, oMemRd, oBoth, oAdrBad, oImmBad, oTimeout;
  logic [1:0] oResAtRw;
  logic [2:0] oExecAlu, oLastAlu;
  logic       oLastPcWr;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .mem_read(mem_read),
    .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_control(alu_control), .illegal(illegal), .retire(retire)
  );

  // Reference: immediate format by opcode.
  function automatic logic [1:0] expImm(input logic [6:0] o);
    if (o == T_SW) return 2'd1;
    if (o == T_BEQ) return 2'd2;
    if (o == T_JAL) return 2'd3;
    return 2'd0;
  endfunction

  // Reference: ALU operation for R/I execution.
  function automatic logic [2:0] expAlu(input logic isR, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (isR && f7) ? 3'b001 : 3'b000;
      3'd2:    return 3'b101;
      3'd6:    return 3'b011;
      3'd7:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Reference: cycles per instruction including memory waits.
  function automatic int expCycles(input logic [6:0] o, input int fw, input int dw);
    case (o)
      T_LW:    return 5 + fw + dw;
      T_SW:    return 4 + fw + dw;
      T_BEQ:   return 3 + fw;
      default: return 4 + fw;
    endcase
  endfunction

  // Drive one instruction from its fetch cycle to retire. Memory answers after
  // fw wait cycles for the fetch and dw for the data access; mem_ready toggles
  // randomly whenever no request is pending.
  task automatic runInstr(input logic [6:0] iop, input logic [2:0] if3, input logic if7,
                          input logic izero, input int fw, input int dw);
    int cyc = 0;
    int access = 0;
    int held = 0;
    logic req;
    op = iop; funct3 = if3; funct7b5 = if7;
    oRegWr = 0; oRegWrCycle = 0; oRes01 = 0; oPcWr = 0; oIrWr = 0; oMemWr = 0;
    oMemWrAdr = 0; oMemRd = 0; oBoth = 0; oAdrBad = 0; oImmBad = 0; oTimeout = 0;
    oResAtRw = 2'd3; oExecAlu = 3'd7; oLastAlu = 3'd7; oLastPcWr = 1'b0;
    while (1) begin
      @(negedge clk);
      cyc++;
      req  = mem_read | mem_write;
      zero = (iop == T_BEQ) ? izero : 1'($urandom_range(0, 1));
      if (req) mem_ready = (held == ((access == 0) ? fw : dw));
      else     mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (reg_write) begin oRegWr++; oRegWrCycle = cyc; oResAtRw = result_src; end
      if (result_src == 2'b01) oRes01++;
      if (pc_write) oPcWr++;
      if (ir_write) oIrWr++;
      if (mem_write) oMemWr++;
      if (mem_write && adr_src) oMemWrAdr++;
      if (mem_read) oMemRd++;
      if (mem_read && mem_write) oBoth++;
      if (req && (adr_src !== ((access == 0) ? 1'b0 : 1'b1))) oAdrBad++;
      if (imm_src !== expImm(iop)) oImmBad++;
      if (cyc == fw + 3) oExecAlu = alu_control;
      oLastAlu = alu_control;
      oLastPcWr = pc_write;
      if (req) begin
        if (mem_ready) begin access++; held = 0; end
        else held++;
      end
      if (retire) break;
      if (cyc >= 40) begin oTimeout = 1; break; end
    end
    oCycles = cyc;
  endtask

  // Assert reset for n edges starting at a negedge; ends just after release.
  task automatic doReset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b1; zero = 1'b1; op = T_LW;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({mem_write, pc_write, reg_write, ir_write, retire} !== 5'b0) begin
        errors++;
        $display("FAIL reset_enables cyc%0d: got %b expected 00000", i,
                 {mem_write, pc_write, reg_write, ir_write, retire});
      end
    end
    mem_ready = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if ({mem_read, adr_src, illegal} !== 3'b100) begin
      errors++;
      $display("FAIL reset_release_fetch: got mem_read/adr_src/illegal=%b expected 100",
               {mem_read, adr_src, illegal});
    end
    $display("test_reset done");
  endtask

  task automatic test_lw();
    runInstr(T_LW, 3'd2, 1'b0, 1'b0, 0, 0);
    checks++;
    if (oCycles != 5) begin errors++; $display("FAIL lw_cycles: got %0d expected 5", oCycles); end
    checks++;
    if (oRegWr != 1 || oRegWrCycle != 5) begin
      errors++; $display("FAIL lw_regwrite: got count %0d at cycle %0d expected 1 at 5", oRegWr, oRegWrCycle);
    end
    checks++;
    if (oRes01 != 1 || oResAtRw !== 2'b01) begin
      errors++; $display("FAIL lw_result_src: got %0d cycles of 01, %b at write expected 1 and 01", oRes01, oResAtRw);
    end
    $display("lw: cycles=%0d reg_write@%0d", oCycles, oRegWrCycle);
  endtask

  task automatic test_sw_wait();
    runInstr(T_SW, 3'd2, 1'b0, 1'b0, 0, 3);
    checks++;
    if (oMemWr != 4 || oMemWrAdr != 4) begin
      errors++; $display("FAIL sw_hold: got mem_write %0d adr_src %0d cycles expected 4 and 4", oMemWr, oMemWrAdr);
    end
    checks++;
    if (oCycles != 7) begin errors++; $display("FAIL sw_cycles: got %0d expected 7", oCycles); end
    checks++;
    if (oRegWr != 0) begin errors++; $display("FAIL sw_regwrite: got %0d expected 0", oRegWr); end
    $display("sw: cycles=%0d mem_write cycles=%0d", oCycles, oMemWr);
  endtask

  task automatic test_alu_decode();
    runInstr(T_R, 3'd0, 1'b1, 1'b0, 0, 0);
    checks++;
    if (oExecAlu !== 3'b001) begin errors++; $display("FAIL rtype_sub: got %b expected 001", oExecAlu); end
    $display("R sub: alu_control=%b", oExecAlu);
    runInstr(T_I, 3'd0, 1'b1, 1'b0, 0, 0);
    checks++;
    if (oExecAlu !== 3'b000) begin errors++; $display("FAIL addi_bit30: got %b expected 000", oExecAlu); end
    $display("addi bit30: alu_control=%b", oExecAlu);
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      runInstr(T_BEQ, 3'd0, 1'b0, 1'(z), 0, 0);
      checks++;
      if (oLastPcWr !== 1'(z)) begin
        errors++; $display("FAIL beq_pc_write z=%0d: got %b expected %0d", z, oLastPcWr, z);
      end
      checks++;
      if (oCycles != 3) begin errors++; $display("FAIL beq_cycles z=%0d: got %0d expected 3", z, oCycles); end
      checks++;
      if (oLastAlu !== 3'b001) begin errors++; $display("FAIL beq_sub z=%0d: got %b expected 001", z, oLastAlu); end
      $display("beq zero=%0d: cycles=%0d pc_write=%b", z, oCycles, oLastPcWr);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] ops [6];
    ops[0] = T_LW; ops[1] = T_SW; ops[2] = T_R; ops[3] = T_I; ops[4] = T_JAL; ops[5] = T_BEQ;
    for (int n = 0; n < 40; n++) begin
      logic [6:0] o;
      logic [2:0] f3;
      logic       f7, z;
      int         fw, dw, expPc, expRw, expMr, expMw;
      o  = ops[$urandom_range(0, 5)];
      f3 = 3'($urandom_range(0, 7));
      f7 = 1'($urandom_range(0, 1));
      z  = 1'($urandom_range(0, 1));
      fw = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      runInstr(o, f3, f7, z, fw, dw);
      expPc = 1 + ((o == T_JAL) ? 1 : 0) + ((o == T_BEQ && z) ? 1 : 0);
      expRw = (o == T_SW || o == T_BEQ) ? 0 : 1;
      expMr = fw + 1 + ((o == T_LW) ? dw + 1 : 0);
      expMw = (o == T_SW) ? dw + 1 : 0;
      checks++;
      if (oTimeout != 0 || oCycles != expCycles(o, fw, dw)) begin
        errors++; $display("FAIL rnd%0d_cycles op=%b: got %0d expected %0d", n, o, oCycles, expCycles(o, fw, dw));
      end
      checks++;
      if (oPcWr != expPc || oIrWr != 1) begin
        errors++; $display("FAIL rnd%0d_pc_ir op=%b: got pc %0d ir %0d expected %0d and 1", n, o, oPcWr, oIrWr, expPc);
      end
      checks++;
      if (oRegWr != expRw || (expRw == 1 && oRegWrCycle != oCycles)) begin
        errors++; $display("FAIL rnd%0d_regwrite op=%b: got %0d at %0d expected %0d at %0d", n, o, oRegWr, oRegWrCycle, expRw, oCycles);
      end
      checks++;
      if (oMemRd != expMr || oMemWr != expMw || oBoth != 0) begin
        errors++; $display("FAIL rnd%0d_mem op=%b: got rd %0d wr %0d both %0d expected %0d %0d 0", n, o, oMemRd, oMemWr, oBoth, expMr, expMw);
      end
      checks++;
      if (oAdrBad != 0 || oImmBad != 0) begin
        errors++; $display("FAIL rnd%0d_adr_imm op=%b: got %0d bad adr_src %0d bad imm_src expected 0 0", n, o, oAdrBad, oImmBad);
      end
      if (o == T_R || o == T_I) begin
        checks++;
        if (oExecAlu !== expAlu(o == T_R, f3, f7)) begin
          errors++; $display("FAIL rnd%0d_alu op=%b f3=%0d f7=%b: got %b expected %b", n, o, f3, f7, oExecAlu, expAlu(o == T_R, f3, f7));
        end
      end
      $display("instr %0d op=%b fw=%0d dw=%0d cycles=%0d", n, o, fw, dw, oCycles);
    end
  endtask

  task automatic test_illegal();
    doReset(1);
    op = 7'b1111111; mem_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag cyc%0d: got %b expected 1", i, illegal); end
      checks++;
      if ({mem_read, mem_write, ir_write, pc_write, reg_write, retire} !== 6'b0) begin
        errors++; $display("FAIL illegal_enables cyc%0d: got %b expected 000000", i,
                           {mem_read, mem_write, ir_write, pc_write, reg_write, retire});
      end
    end
    doReset(1);
    mem_ready = 1'b0;
    #1;
    checks++;
    if ({illegal, mem_read} !== 2'b01) begin
      errors++; $display("FAIL illegal_reset: got illegal/mem_read=%b expected 01", {illegal, mem_read});
    end
    $display("illegal trap held 10 cycles, cleared by reset");
  endtask

  task automatic test_reset_mid_access();
    doReset(1);
    op = T_SW; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 mem_ready = 1'b0;
    #1;
    checks++;
    if (mem_write !== 1'b1) begin errors++; $display("FAIL mid_memwrite: got %b expected 1", mem_write); end
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b1;
    #1;
    checks++;
    if ({mem_write, retire} !== 2'b00) begin
      errors++; $display("FAIL mid_reset_gate: got mem_write/retire=%b expected 00", {mem_write, retire});
    end
    @(posedge clk);
    #1 rst = 1'b0; mem_ready = 1'b0;
    #1;
    checks++;
    if ({mem_read, mem_write, adr_src} !== 3'b100) begin
      errors++; $display("FAIL mid_reset_fetch: got %b expected 100", {mem_read, mem_write, adr_src});
    end
    $display("reset during MEMWRITE returned to FETCH");
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_alu_decode();
    test_beq();
    test_back_to_back();
    test_illegal();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
